priority_mux_sel: RTL and testbench
===================================

Name: priority_mux_sel

Overview:
- Parameterised priority multiplexer. Selects one of CNT packed WIDTH-bit data slices using a request vector `sel`; the lowest asserted index wins.
- Used inside software-access field control logic in two places:
  - to pick write data from several software write ports;
  - to arbitrate the onread value against the onwrite value that forms the next field value.
- Output is combinational by default, with an optional registered output stage.

Parameters:
- WIDTH, 4, bit width of each data slice and of dout; must be ≥1.
- CNT, 1, number of candidate slices and sel bits; must be ≥1.
- REG_OUT, 0, 0 = combinational dout; 1 = dout registered on clk.

Ports:
- clk  input  1  clock; used only when REG_OUT=1.
- rst  input  1  asynchronous, active-high reset; used only when REG_OUT=1.
- din  input  WIDTH*CNT  packed candidates; slice i = din[i*WIDTH +: WIDTH].
- sel  input  CNT  request vector; bit i selects slice i.
- dout  output  WIDTH  selected slice.
- hit  output  1  OR-reduction of sel; same timing as dout.

Behaviour:
- Priority: index 0 is highest. If sel[k] is the lowest set bit, then dout = slice k.
- Higher-index requests are ignored while any lower-index request is asserted.
- No sel bit set: dout = all zeros and hit = 0. This never floats or holds a stale value; consumers gate with hit.
- hit = |sel.
- CNT=1: dout = sel[0] ? din : 0.
- REG_OUT=0:
  - Pure combinational, zero latency.
  - clk and rst are ignored.
  - No latches: every path assigns a value.
- REG_OUT=1:
  - The combinational result is registered on the rising edge of clk, so dout and hit follow sel/din with a latency of 1 cycle.
  - rst asserted (asynchronously, at any time, including mid-stream) forces dout = 0 and hit = 0 immediately. Both stay 0 while rst is high.
  - The first edge after rst deasserts captures the current inputs.
- Width rules:
  - No arithmetic.
  - din slices map LSB-first: slice 0 occupies din[WIDTH-1:0].
- X/illegal handling: an X on a sel bit that has a lower-index 1 does not propagate.
- Elaboration check: WIDTH<1 or CNT<1 produces a fatal message at elaboration.

Decomposition:
- No package typedefs required; the module is self-contained.
- A natural sub-module is prio_onehot. It converts sel to a one-hot grant by isolating the lowest set bit (sel & (~sel + 1)).
- The mux then AND-ORs the din slices with the grant bits; this structure is preferred over an if-chain for timing.
- The optional register is a generate branch in the top module.

Test Plan:
- WIDTH=4, CNT=2, din={4'hA,4'h5}, sel=2'b11 -> dout=4'h5, hit=1 (index 0 wins).
- Same din, sel=2'b10 -> dout=4'hA. sel=2'b00 -> dout=4'h0, hit=0.
- WIDTH=8, CNT=4:
  - din={8'h44,8'h33,8'h22,8'h11}, sel=4'b1100 -> dout=8'h33.
  - sel=4'b1000 -> dout=8'h44.
  - sweep all 16 sel values against the reference model.
- CNT=1, WIDTH=4, din=4'h9:
  - sel=1 -> dout=4'h9.
  - sel=0 -> dout=0.
- REG_OUT=1, WIDTH=4, CNT=2:
  - sel=2'b01, din slice0=4'h7 -> dout=4'h7 one cycle later.
  - assert rst mid-cycle -> dout=0 immediately, before the next clk edge.
  - release rst -> the next edge reloads 4'h7.
- Randomised: 1000 cycles of random din/sel at WIDTH=5, CNT=3 -> dout matches a lowest-index-first model every cycle.

Source files
------------

// File: rtl/priority_mux_sel_pkg.sv
// priority_mux_sel_pkg
//   Shared constants for the priority multiplexer slice.
//   MIN_WIDTH / MIN_CNT : smallest legal slice width and candidate count,
//                         checked when priority_mux_sel elaborates.
package priority_mux_sel_pkg;

  localparam int MIN_WIDTH = 1;
  localparam int MIN_CNT   = 1;

endpackage : priority_mux_sel_pkg

// File: rtl/priority_mux_sel_prio_onehot.sv
// prio_onehot
//   Converts a request vector into a one-hot grant that keeps only the
//   lowest set bit. The function is sel & (~sel + 1), but it is built as a
//   prefix-OR chain. With a chain, an unknown on a higher request bit is
//   masked by any lower request that is 1. The carry form would pass that
//   unknown through to the grant.
// Ports:
//   sel   [CNT-1:0] : request vector, bit 0 has the highest priority
//   grant [CNT-1:0] : one-hot (or all-zero) grant of the lowest set bit
module prio_onehot #(
  parameter int CNT = 1
) (
  input  logic [CNT-1:0] sel,
  output logic [CNT-1:0] grant
);

  // lower_set is true when any request below bit i is asserted.
  logic lower_set;

  always_comb begin
    grant     = '0;
    lower_set = 1'b0;
    for (int i = 0; i < CNT; i++) begin
      grant[i]  = sel[i] & ~lower_set;
      lower_set = lower_set | sel[i];
    end
  end

endmodule : prio_onehot

// File: rtl/priority_mux_sel.sv
// priority_mux_sel
//   Priority multiplexer. It picks one of CNT packed WIDTH-bit slices from
//   din. The lowest-index asserted sel bit wins. When no sel bit is set,
//   dout is zero and hit is 0, so consumers can simply gate with hit. The
//   output is combinational by default. With REG_OUT=1 it is registered
//   with one cycle of latency.
// Parameters:
//   WIDTH   : bits per slice and width of dout (>= 1)
//   CNT     : number of candidate slices / sel bits (>= 1)
//   REG_OUT : 0 = combinational outputs, 1 = outputs registered on clk
// Ports:
//   clk  : clock, used only when REG_OUT=1
//   rst  : asynchronous active-high reset, used only when REG_OUT=1
//   din  [WIDTH*CNT-1:0] : candidates, slice i = din[i*WIDTH +: WIDTH]
//   sel  [CNT-1:0]       : request vector, bit 0 highest priority
//   dout [WIDTH-1:0]     : selected slice (zero when no request)
//   hit                  : OR of sel, same timing as dout
module priority_mux_sel
  import priority_mux_sel_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CNT     = 1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH*CNT-1:0] din,
  input  logic [CNT-1:0]       sel,
  output logic [WIDTH-1:0]     dout,
  output logic                 hit
);

  if (WIDTH < MIN_WIDTH || CNT < MIN_CNT) begin : g_bad_params
    $fatal(1, "priority_mux_sel: WIDTH (%0d) and CNT (%0d) must both be >= 1",
           WIDTH, CNT);
  end

  logic [CNT-1:0]   grant;
  logic [WIDTH-1:0] mux_d;
  logic             hit_d;

  prio_onehot #(.CNT(CNT)) u_prio_onehot (
    .sel   (sel),
    .grant (grant)
  );

  // AND-OR mux. The grant has at most one bit set, so the OR never combines
  // two slices. An empty grant gives all zeros.
  always_comb begin
    mux_d = '0;
    for (int i = 0; i < CNT; i++) begin
      mux_d = mux_d | (din[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  assign hit_d = |sel;

  if (REG_OUT) begin : g_reg_out
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout <= '0;
        hit  <= 1'b0;
      end else begin
        dout <= mux_d;
        hit  <= hit_d;
      end
    end
  end else begin : g_comb_out
    // clk and rst have no function in the combinational variant.
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst;
    assign dout = mux_d;
    assign hit  = hit_d;
  end

endmodule : priority_mux_sel

// File: tb/tb_priority_mux_sel.sv
// tb_priority_mux_sel
//   Bench for priority_mux_sel. It drives several parameterisations, pushes
//   the expected {hit, dout} values into queues as stimulus is driven, and
//   pops and compares them when each DUT produces its output.
module tb_priority_mux_sel;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  // a: WIDTH=4 CNT=2 comb
  logic [7:0]  a_din = '0;
  logic [1:0]  a_sel = '0;
  logic [3:0]  a_dout;
  logic        a_hit;
  // b: WIDTH=8 CNT=4 comb
  logic [31:0] b_din = '0;
  logic [3:0]  b_sel = '0;
  logic [7:0]  b_dout;
  logic        b_hit;
  // c: WIDTH=4 CNT=1 comb
  logic [3:0]  c_din = '0;
  logic [0:0]  c_sel = '0;
  logic [3:0]  c_dout;
  logic        c_hit;
  // d: WIDTH=4 CNT=2 registered
  logic [7:0]  d_din = '0;
  logic [1:0]  d_sel = '0;
  logic [3:0]  d_dout;
  logic        d_hit;
  // e / f: WIDTH=5 CNT=3, comb and registered, shared inputs
  logic [14:0] e_din = '0;
  logic [2:0]  e_sel = '0;
  logic [4:0]  e_dout, f_dout;
  logic        e_hit, f_hit;

  priority_mux_sel #(.WIDTH(4), .CNT(2), .REG_OUT(1'b0)) u_a (
    .clk(clk), .rst(rst), .din(a_din), .sel(a_sel), .dout(a_dout), .hit(a_hit));
  priority_mux_sel #(.WIDTH(8), .CNT(4), .REG_OUT(1'b0)) u_b (
    .clk(clk), .rst(rst), .din(b_din), .sel(b_sel), .dout(b_dout), .hit(b_hit));
  priority_mux_sel #(.WIDTH(4), .CNT(1), .REG_OUT(1'b0)) u_c (
    .clk(clk), .rst(rst), .din(c_din), .sel(c_sel), .dout(c_dout), .hit(c_hit));
  priority_mux_sel #(.WIDTH(4), .CNT(2), .REG_OUT(1'b1)) u_d (
    .clk(clk), .rst(rst), .din(d_din), .sel(d_sel), .dout(d_dout), .hit(d_hit));
  priority_mux_sel #(.WIDTH(5), .CNT(3), .REG_OUT(1'b0)) u_e (
    .clk(clk), .rst(rst), .din(e_din), .sel(e_sel), .dout(e_dout), .hit(e_hit));
  priority_mux_sel #(.WIDTH(5), .CNT(3), .REG_OUT(1'b1)) u_f (
    .clk(clk), .rst(rst), .din(e_din), .sel(e_sel), .dout(f_dout), .hit(f_hit));

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_reg_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // {hit, dout} packed as hit at bit 16, dout in the low bits.
  function automatic logic [W-1:0] pack(input logic hit, input logic [15:0] d);
    return {15'b0, hit, d};
  endfunction

  // Reference: walk from index 0 upward and take the first set request.
  function automatic logic [W-1:0] ref_mux(input logic [63:0] din,
                                           input logic [7:0] sel,
                                           input int width, input int cnt);
    logic [15:0] d;
    logic        found;
    d = '0;
    found = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      if (sel[i] && !found) begin
        found = 1'b1;
        for (int b = 0; b < width; b++) d[b] = din[i*width + b];
      end
    end
    return pack(found, d);
  endfunction

  // Pop the next expected entry and compare it against an observed value.
  task automatic pop_check(input string tag, input logic [W-1:0] obs);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: expected queue empty", tag);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic pop_check_reg(input string tag, input logic [W-1:0] obs);
    if (exp_reg_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: registered expected queue empty", tag);
    end else begin
      check(tag, obs, exp_reg_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input string tag, input logic [7:0] din,
                         input logic [1:0] sel, input logic [3:0] e_d,
                         input logic e_h);
    a_din = din;
    a_sel = sel;
    exp_q.push_back(pack(e_h, {12'b0, e_d}));
    #1;
    pop_check(tag, pack(a_hit, {12'b0, a_dout}));
  endtask

  task automatic drive_b(input string tag, input logic [3:0] sel,
                         input logic [W-1:0] exp);
    b_sel = sel;
    exp_q.push_back(exp);
    #1;
    pop_check(tag, pack(b_hit, {8'b0, b_dout}));
  endtask

  task automatic drive_c(input string tag, input logic [3:0] din,
                         input logic sel, input logic [3:0] e_d,
                         input logic e_h);
    c_din = din;
    c_sel = sel;
    exp_q.push_back(pack(e_h, {12'b0, e_d}));
    #1;
    pop_check(tag, pack(c_hit, {12'b0, c_dout}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Registered instance: reset state, with inputs already requesting 7.
    d_din = 8'h07;
    d_sel = 2'b01;
    @(posedge clk); #1;
    check("reg_reset_state", pack(d_hit, {12'b0, d_dout}), pack(1'b0, 16'h0));

    // a: WIDTH=4 CNT=2, din={A,5}
    drive_a("a_sel11", 8'hA5, 2'b11, 4'h5, 1'b1);
    drive_a("a_sel10", 8'hA5, 2'b10, 4'hA, 1'b1);
    drive_a("a_sel00", 8'hA5, 2'b00, 4'h0, 1'b0);
    drive_a("a_sel01", 8'hA5, 2'b01, 4'h5, 1'b1);

    // b: WIDTH=8 CNT=4
    b_din = 32'h44332211;
    drive_b("b_sel1100", 4'b1100, pack(1'b1, 16'h0033));
    drive_b("b_sel1000", 4'b1000, pack(1'b1, 16'h0044));
    for (int s = 0; s < 16; s++) begin
      logic [3:0] sv;
      sv = 4'(s);
      drive_b($sformatf("b_sweep_%0d", s), sv,
              ref_mux({32'b0, b_din}, {4'b0, sv}, 8, 4));
    end

    // c: CNT=1
    drive_c("c_sel1", 4'h9, 1'b1, 4'h9, 1'b1);
    drive_c("c_sel0", 4'h9, 1'b0, 4'h0, 1'b0);

    // d: registered path
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reg_first_load", pack(d_hit, {12'b0, d_dout}), pack(1'b1, 16'h7));
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("reg_async_rst", pack(d_hit, {12'b0, d_dout}), pack(1'b0, 16'h0));
    @(posedge clk); #1;
    check("reg_rst_held", pack(d_hit, {12'b0, d_dout}), pack(1'b0, 16'h0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reg_reload", pack(d_hit, {12'b0, d_dout}), pack(1'b1, 16'h7));
    @(negedge clk);
    d_sel = 2'b00;
    #1;
    check("reg_latency_hold", pack(d_hit, {12'b0, d_dout}), pack(1'b1, 16'h7));
    @(posedge clk); #1;
    check("reg_latency_zero", pack(d_hit, {12'b0, d_dout}), pack(1'b0, 16'h0));

    // e / f: random WIDTH=5 CNT=3
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] exp;
      @(negedge clk);
      e_din = 15'($urandom_range(0, 32767));
      e_sel = 3'($urandom_range(0, 7));
      exp = ref_mux({49'b0, e_din}, {5'b0, e_sel}, 5, 3);
      exp_q.push_back(exp);
      exp_reg_q.push_back(exp);
      #1;
      pop_check("rand_comb", pack(e_hit, {11'b0, e_dout}));
      @(posedge clk); #1;
      pop_check_reg("rand_reg", pack(f_hit, {11'b0, f_dout}));
    end

    check("queues_drained", W'(exp_q.size() + exp_reg_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_priority_mux_sel
